// File: rtl/score_bcd_counter.sv
// Packed-BCD game score counter with saturation, best-score retention and a
// registered display word for the seven-segment decoder.
module score_bcd_counter #(
  parameter int MAX_HUNDS = 3,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       score_evt,
  input  logic       show_best,
  output logic [9:0] bcd_data,
  output logic [9:0] score_bcd,
  output logic [9:0] best_bcd,
  output logic [1:0] state,
  output logic       saturated,
  output logic       new_best
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAYING = 2'b01,
    OVER    = 2'b10
  } state_t;

  localparam logic [9:0] CEIL = {2'(MAX_HUNDS), 8'h99};

  state_t     state_reg, state_next;
  logic [9:0] score_reg, score_next;
  logic [9:0] best_reg, best_next;
  logic [9:0] bcd_reg, bcd_next;
  logic [9:0] score_inc;
  logic       sat_reg, sat_next;
  logic       new_best_reg, new_best_next;
  logic       evt_q_reg;
  logic       inc;
  logic [2:0] carry;

  // Ripple a decimal carry through units and tens; hundreds takes the final carry.
  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit                 = score_reg[4*gi +: 4];
      assign carry[gi+1]           = carry[gi] & (digit == 4'd9);
      assign score_inc[4*gi +: 4]  = carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
    end
  endgenerate

  assign score_inc[9:8] = score_reg[9:8] + {1'b0, carry[2]};

  assign inc = (state_reg == PLAYING) &&
               (EDGE_MODE ? (score_evt && !evt_q_reg) : score_evt);

  always_comb begin
    state_next    = state_reg;
    score_next    = score_reg;
    best_next     = best_reg;
    new_best_next = new_best_reg;
    if (game_start) begin
      state_next    = PLAYING;
      score_next    = 10'h000;
      new_best_next = 1'b0;
    end else if (game_over && state_reg == PLAYING) begin
      state_next = OVER;
      if (score_reg > best_reg) begin
        best_next     = score_reg;
        new_best_next = 1'b1;
      end
    end else if (inc && score_reg != CEIL) begin
      score_next = score_inc;
    end
    sat_next = (score_next == CEIL);
    bcd_next = show_best ? best_next : score_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      score_reg    <= 10'h000;
      best_reg     <= 10'h000;
      bcd_reg      <= 10'h000;
      sat_reg      <= 1'b0;
      new_best_reg <= 1'b0;
      evt_q_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      score_reg    <= score_next;
      best_reg     <= best_next;
      bcd_reg      <= bcd_next;
      sat_reg      <= sat_next;
      new_best_reg <= new_best_next;
      evt_q_reg    <= score_evt;
    end
  end

  assign bcd_data  = bcd_reg;
  assign score_bcd = score_reg;
  assign best_bcd  = best_reg;
  assign state     = state_reg;
  assign saturated = sat_reg;
  assign new_best  = new_best_reg;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: edge-mode and level-mode instances share stimulus
// and are compared every cycle against an integer-score reference model.
module tb_score_bcd_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, game_start, game_over, score_evt, show_best;

  logic [9:0] e_bcd, e_score, e_best, l_bcd, l_score, l_best;
  logic [1:0] e_state, l_state;
  logic       e_sat, e_nb, l_sat, l_nb;

  score_bcd_counter #(.MAX_HUNDS(3), .EDGE_MODE(1'b1)) dut_edge (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .score_evt(score_evt), .show_best(show_best), .bcd_data(e_bcd),
    .score_bcd(e_score), .best_bcd(e_best), .state(e_state),
    .saturated(e_sat), .new_best(e_nb)
  );

  score_bcd_counter #(.MAX_HUNDS(3), .EDGE_MODE(1'b0)) dut_level (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .score_evt(score_evt), .show_best(show_best), .bcd_data(l_bcd),
    .score_bcd(l_score), .best_bcd(l_best), .state(l_state),
    .saturated(l_sat), .new_best(l_nb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: scores kept as plain integers, index 1 = edge mode, 0 = level mode.
  localparam int CEIL = 399;
  int m_score[2], m_best[2], m_state[2], m_nb[2], m_prev[2], m_disp[2];

  function automatic logic [9:0] to_bcd(input int v);
    return 10'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_score[m] = 0; m_best[m] = 0; m_state[m] = 0;
      m_nb[m] = 0; m_prev[m] = 0; m_disp[m] = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      bit hit;
      hit = (m_state[m] == 1) && ((m == 1) ? (score_evt && m_prev[m] == 0) : score_evt);
      if (game_start) begin
        m_state[m] = 1; m_score[m] = 0; m_nb[m] = 0;
      end else if (game_over && m_state[m] == 1) begin
        m_state[m] = 2;
        if (m_score[m] > m_best[m]) begin
          m_best[m] = m_score[m];
          m_nb[m]   = 1;
        end
      end else if (hit && m_score[m] < CEIL) begin
        m_score[m]++;
      end
      m_prev[m] = score_evt ? 1 : 0;
      m_disp[m] = show_best ? m_best[m] : m_score[m];
    end
  endtask

  task automatic check_all();
    check_val("e_score", e_score, to_bcd(m_score[1]));
    check_val("e_best",  e_best,  to_bcd(m_best[1]));
    check_val("e_bcd",   e_bcd,   to_bcd(m_disp[1]));
    check_val("e_state", 10'(e_state), 10'(m_state[1]));
    check_val("e_sat",   10'(e_sat), 10'(m_score[1] == CEIL));
    check_val("e_nb",    10'(e_nb),  10'(m_nb[1]));
    check_val("l_score", l_score, to_bcd(m_score[0]));
    check_val("l_best",  l_best,  to_bcd(m_best[0]));
    check_val("l_bcd",   l_bcd,   to_bcd(m_disp[0]));
    check_val("l_state", 10'(l_state), 10'(m_state[0]));
    check_val("l_sat",   10'(l_sat), 10'(m_score[0] == CEIL));
    check_val("l_nb",    10'(l_nb),  10'(m_nb[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic pulse(input int hi, input int lo);
    score_evt = 1'b1;
    repeat (hi) tick();
    score_evt = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic start_game();
    game_start = 1'b1; tick(); game_start = 1'b0;
  endtask

  task automatic end_game();
    game_over = 1'b1; tick(); game_over = 1'b0;
  endtask

  initial begin
    rst = 1'b1; game_start = 1'b0; game_over = 1'b0; score_evt = 1'b0; show_best = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_val("reset_state", 10'(e_state), 10'h000);
    check_val("reset_bcd", e_bcd, 10'h000);
    $display("txn reset: state=%b score=%h", e_state, e_score);

    // Asynchronous reset in the middle of a game
    start_game();
    repeat (57) pulse(1, 1);
    check_val("score57", e_score, 10'h057);
    #2 rst = 1'b1;
    #1;
    check_val("arst_score", e_score, 10'h000);
    check_val("arst_bcd", e_bcd, 10'h000);
    check_val("arst_state", 10'(e_state), 10'h000);
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
    tick();
    repeat (3) pulse(1, 1);
    check_val("idle_nocount", e_score, 10'h000);
    $display("txn async reset: score=%h state=%b", e_score, e_state);

    // Decimal carries
    start_game();
    repeat (10) pulse(3, 1);
    check_val("carry10", e_score, 10'h010);
    $display("txn carry10: score=%h", e_score);
    start_game();
    repeat (100) pulse(3, 1);
    check_val("carry100", e_score, 10'h100);
    $display("txn carry100: score=%h", e_score);

    // Saturation
    start_game();
    repeat (410) pulse(1, 1);
    check_val("sat_score", e_score, 10'h399);
    check_val("sat_flag", 10'(e_sat), 10'h001);
    pulse(1, 1);
    check_val("sat_hold", e_score, 10'h399);
    $display("txn saturation: score=%h sat=%b", e_score, e_sat);

    // Best-score tracking over three games
    start_game(); repeat (25) pulse(1, 1); end_game();
    check_val("g1_best", e_best, 10'h025);
    check_val("g1_nb", 10'(e_nb), 10'h001);
    $display("txn game1: best=%h new_best=%b", e_best, e_nb);
    start_game(); repeat (17) pulse(1, 1); end_game();
    check_val("g2_best", e_best, 10'h025);
    check_val("g2_nb", 10'(e_nb), 10'h000);
    $display("txn game2: best=%h new_best=%b", e_best, e_nb);
    start_game(); repeat (25) pulse(1, 1); end_game();
    check_val("g3_nb", 10'(e_nb), 10'h000);
    $display("txn game3: best=%h new_best=%b", e_best, e_nb);
    show_best = 1'b1; tick();
    check_val("show_best", e_bcd, 10'h025);
    show_best = 1'b0; tick();
    $display("txn show_best: bcd=%h", e_bcd);

    // Simultaneous strobes
    start_game(); repeat (9) pulse(1, 1);
    game_over = 1'b1; score_evt = 1'b1; tick();
    check_val("over_evt_state", 10'(e_state), 10'h002);
    check_val("over_evt_score", e_score, 10'h009);
    game_over = 1'b0; score_evt = 1'b0; tick();
    game_start = 1'b1; game_over = 1'b1; tick();
    game_start = 1'b0; game_over = 1'b0;
    check_val("start_over_state", 10'(e_state), 10'h001);
    check_val("start_over_score", e_score, 10'h000);
    $display("txn simultaneous: state=%b score=%h", e_state, e_score);

    // Edge register survives game_start
    end_game();
    score_evt = 1'b1; repeat (2) tick();
    start_game(); repeat (2) tick();
    check_val("held_start", e_score, 10'h000);
    score_evt = 1'b0; tick();
    pulse(1, 1);
    check_val("held_then_edge", e_score, 10'h001);
    $display("txn held across start: score=%h", e_score);

    // Level mode counts every high cycle, only while playing
    start_game();
    pulse(5, 1);
    check_val("level5", l_score, 10'h005);
    check_val("edge1", e_score, 10'h001);
    end_game();
    pulse(4, 1);
    check_val("level_over", l_score, 10'h005);
    $display("txn level mode: level=%h edge=%h", l_score, e_score);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      game_start = ($urandom_range(0, 59) == 0);
      game_over  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) score_evt = ~score_evt;
      if ($urandom_range(0, 7) == 0) show_best = ~show_best;
      tick();
    end
    game_start = 1'b0; game_over = 1'b0; score_evt = 1'b0; show_best = 1'b0;
    $display("txn random: score=%h best=%h state=%b", e_score, e_best, e_state);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
